// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO registers (MIPS-style).
// Ports: clk, reset, start, op[2:0], a, b, cancel -> busy, done, hi, lo.
// Optional macro MULDIV_DIV_EN adds DIV/DIVU; otherwise those codes are ignored.
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   bm_q, bm_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic           isdiv_q, isdiv_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   araw_q, araw_d;
`endif

  // Signed variants are the even op codes (MULT, DIV).
  logic           sgn_op;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_abs, prod_fix;

  assign sgn_op   = ~op[0];
  assign a_mag    = (sgn_op && a[W-1]) ? ('0 - a) : a;
  assign b_mag    = (sgn_op && b[W-1]) ? ('0 - b) : b;
  // Shift-add: rem_q holds the upper partial product, q_q the multiplier.
  assign mul_sum  = {1'b0, rem_q} + (q_q[0] ? {1'b0, bm_q} : {(W+1){1'b0}});
  assign prod_abs = {rem_q, q_q};
  assign prod_fix = neg_q ? ('0 - prod_abs) : prod_abs;

`ifdef MULDIV_DIV_EN
  // Restoring divide: rem_q is the partial remainder, q_q shifts the
  // dividend out at the top and the quotient in at the bottom.
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_diff;

  assign div_sh   = {rem_q, q_q[W-1]};
  assign div_ge   = div_sh >= {1'b0, bm_q};
  assign div_diff = div_sh[W-1:0] - bm_q;
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    bm_d    = bm_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    isdiv_d = isdiv_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    araw_d  = araw_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = '0;
              rem_d   = '0;
              q_d     = a_mag;
              bm_d    = b_mag;
              neg_d   = sgn_op && (a[W-1] ^ b[W-1]);
`ifdef MULDIV_DIV_EN
              isdiv_d = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = '0;
              rem_d   = '0;
              q_d     = a_mag;
              bm_d    = b_mag;
              neg_d   = sgn_op && (a[W-1] ^ b[W-1]);
              isdiv_d = 1'b1;
              rneg_d  = sgn_op && a[W-1];
              dz_d    = (b == '0);
              araw_d  = a;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = FIX;
`ifdef MULDIV_DIV_EN
          if (isdiv_q) begin
            rem_d = div_ge ? div_diff : div_sh[W-1:0];
            q_d   = {q_q[W-2:0], div_ge};
          end else
`endif
          begin
            rem_d = mul_sum[W:1];
            q_d   = {mul_sum[0], q_q[W-1:1]};
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
`ifdef MULDIV_DIV_EN
          if (isdiv_q) begin
            if (dz_q) begin
              lo_d = '1;
              hi_d = araw_q;
            end else begin
              lo_d = neg_q ? ('0 - q_q) : q_q;
              hi_d = rneg_q ? ('0 - rem_q) : rem_q;
            end
          end else
`endif
          begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      bm_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      isdiv_q <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      bm_q    <= bm_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      isdiv_q <= isdiv_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      araw_q  <= araw_d;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv (WIDTH=32).
// Divide vectors apply when MULDIV_DIV_EN is defined; otherwise DIV is checked as ignored.
module tb_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle t0+1; returns k of the done cycle (99 on timeout).
  task automatic wait_done(output int lat, output bit bz_ok);
    lat = 99;
    bz_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        if (busy) bz_ok = 1'b0;
        break;
      end
      if (!busy) bz_ok = 1'b0;
      tick();
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (done) cnt++;
      tick();
    end
  endtask

  initial begin
    int lat, nd;
    bit bz;
    logic [31:0] hsave, lsave;

    vecs.push_back('{"multu_max", 3'b001, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE});
    vecs.push_back('{"mult_neg", 3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"multu_2p32", 3'b001, 32'h10000, 32'h10000, 32'h1, 32'h0});
    vecs.push_back('{"mult_minmin", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
    vecs.push_back('{"mult_m1m1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1});
    vecs.push_back('{"mult_zero", 3'b000, 32'h12345, 32'h0, 32'h0, 32'h0});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{"div_m7_2", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_by0", 3'b011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF});
    vecs.push_back('{"div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
    vecs.push_back('{"divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{"div_7_m2", 3'b010, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD});
    vecs.push_back('{"div_m5_by0", 3'b010, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{"divu_big", 3'b011, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF});
`endif

    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    op = 3'b000; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bz);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'd34);
      chk({vecs[i].name, "_busy"}, 64'(bz), 64'd1);
      chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
      chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      tick();
    end

    // Back-to-back: second MULT issued in the done cycle.
    issue(3'b000, 32'hFFFFFFFD, 32'h5);
    wait_done(lat, bz);
    chk("b2b_first_lat", 64'(lat), 64'd34);
    chk("b2b_first_lo", 64'(lo), 64'hFFFFFFF1);
    issue(3'b000, 32'd6, 32'd7);
    wait_done(lat, bz);
    chk("b2b_second_lat", 64'(lat), 64'd34);
    chk("b2b_second_busy", 64'(bz), 64'd1);
    chk("b2b_second_hi", 64'(hi), 64'd0);
    chk("b2b_second_lo", 64'(lo), 64'd42);
    tick();

    // MTHI/MTLO write immediately with no busy.
    issue(3'b100, 32'h12345678, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h12345678);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(3'b101, 32'hCAFEBABE, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'hCAFEBABE);
    chk("mtlo_hi_kept", 64'(hi), 64'h12345678);

    // Start while busy is ignored; hi/lo hold during RUN.
    issue(3'b001, 32'd3, 32'd4);
    tick(); tick(); tick(); tick();
    issue(3'b001, 32'd9, 32'd9);
    chk("run_hi_hold", 64'(hi), 64'h12345678);
    chk("run_lo_hold", 64'(lo), 64'hCAFEBABE);
    count_done(60, nd);
    chk("busy_start_dones", 64'(nd), 64'd1);
    chk("busy_start_lo", 64'(lo), 64'd12);
    chk("busy_start_busy", 64'(busy), 64'd0);

    // Cancel mid-run keeps prior hi/lo.
    issue(3'b100, 32'hA5A5A5A5, 32'h0);
    issue(3'b000, 32'hFFFFFFFD, 32'h5);
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    count_done(50, nd);
    chk("cancel_dones", 64'(nd), 64'd0);
    chk("cancel_hi", 64'(hi), 64'hA5A5A5A5);
    chk("cancel_lo", 64'(lo), 64'd12);

    // Cancel and start together in IDLE: start discarded.
    cancel = 1'b1;
    issue(3'b000, 32'd2, 32'd2);
    cancel = 1'b0;
    chk("cancel_start_busy", 64'(busy), 64'd0);

    // Reserved op is ignored.
    issue(3'b110, 32'hFFFF, 32'hFFFF);
    chk("rsvd_busy", 64'(busy), 64'd0);
    count_done(40, nd);
    chk("rsvd_dones", 64'(nd), 64'd0);
    chk("rsvd_hi", 64'(hi), 64'hA5A5A5A5);

`ifndef MULDIV_DIV_EN
    hsave = hi;
    lsave = lo;
    issue(3'b010, 32'd100, 32'd7);
    chk("nodiv_busy", 64'(busy), 64'd0);
    count_done(40, nd);
    chk("nodiv_dones", 64'(nd), 64'd0);
    chk("nodiv_hi", 64'(hi), 64'(hsave));
    chk("nodiv_lo", 64'(lo), 64'(lsave));
`else
    hsave = '0;
    lsave = '0;
`endif

    // Reset mid-run discards the op and clears hi/lo.
    issue(3'b000, 32'hFFFFFFFD, 32'h5);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    count_done(50, nd);
    chk("reset_dones", 64'(nd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
